// File: rtl/fetch_ifid.sv
// Instruction fetch stage: owns PC, EPC and halt state, drives a 1-cycle-latency
// instruction memory and presents the IF/ID stream. Macro FETCH_EXC_TRAP_EN enables the illegal-op trap.
module fetch_ifid #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter logic [15:0] EXC_VECTOR = 16'h0002,
  parameter logic [15:0] NOP_INST   = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_en_p1,
  output logic [15:0] imem_addr_p1,
  input  logic [15:0] imem_rdata_p1,
  input  logic        stall_idif_p1,
  input  logic        halt_idif_p1,
  input  logic        illegal_op_idif_p1,
  input  logic        return_execution_idif_p1,
  input  logic        jmp_displacement_idif_p1,
  input  logic [15:0] jmp_displacement_value_idif_p1,
  input  logic        redirect_ixif_p1,
  input  logic [15:0] redirect_target_ixif_p1,
  output logic [15:0] pc_p1,
  output logic [15:0] inst_ifid_p1,
  output logic        inst_valid_ifid_p1,
  output logic [15:0] epc_p1,
  output logic        halted_p1
);

`ifdef FETCH_EXC_TRAP_EN
  localparam bit TrapEn = 1'b1;
`else
  localparam bit TrapEn = 1'b0;
`endif

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] pend_pc_q, pend_pc_d;
  logic        pend_valid_q, pend_valid_d;
  logic [15:0] epc_q, epc_d;

  logic        dec_halt, dec_illegal, dec_rti, dec_jmp;

  // All PC arithmetic wraps modulo 2^16; carry-out is dropped.
  function automatic logic [15:0] pc_add(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] sum;
    sum = a + b;
    return sum;
  endfunction

  // A stalled instruction's decode feedback only acts once it is released.
  assign dec_halt    = halt_idif_p1             & pend_valid_q & ~stall_idif_p1;
  assign dec_illegal = illegal_op_idif_p1       & pend_valid_q & ~stall_idif_p1;
  assign dec_rti     = return_execution_idif_p1 & pend_valid_q & ~stall_idif_p1;
  assign dec_jmp     = jmp_displacement_idif_p1 & pend_valid_q & ~stall_idif_p1;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pend_pc_d    = pend_pc_q;
    pend_valid_d = pend_valid_q;
    epc_d        = epc_q;
    if (state_q == RUN) begin
      if (redirect_ixif_p1) begin
        pc_d         = redirect_target_ixif_p1;
        pend_valid_d = 1'b0;
      end else if (dec_halt) begin
        state_d      = HALTED;
        pend_valid_d = 1'b0;
      end else if (dec_illegal) begin
        pend_valid_d = 1'b0;
        if (TrapEn) begin
          epc_d = pc_add(pend_pc_q, 16'd2);
          pc_d  = EXC_VECTOR;
        end else begin
          state_d = HALTED;
        end
      end else if (dec_rti) begin
        pc_d         = epc_q;
        pend_valid_d = 1'b0;
      end else if (dec_jmp) begin
        pc_d         = pc_add(pc_add(pend_pc_q, 16'd2), jmp_displacement_value_idif_p1);
        pend_valid_d = 1'b0;
      end else if (!stall_idif_p1) begin
        pend_pc_d    = pc_q;
        pend_valid_d = 1'b1;
        pc_d         = pc_add(pc_q, 16'd2);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RUN;
      pc_q         <= RESET_PC;
      pend_pc_q    <= 16'h0000;
      pend_valid_q <= 1'b0;
      epc_q        <= 16'h0000;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pend_pc_q    <= pend_pc_d;
      pend_valid_q <= pend_valid_d;
      epc_q        <= epc_d;
    end
  end

  // Re-reading pend_pc during a stall keeps the returned word stable.
  assign imem_en_p1         = (state_q == RUN);
  assign imem_addr_p1       = stall_idif_p1 ? pend_pc_q : pc_q;
  assign inst_ifid_p1       = pend_valid_q ? imem_rdata_p1 : NOP_INST;
  assign inst_valid_ifid_p1 = pend_valid_q;
  assign pc_p1              = pend_pc_q;
  assign epc_p1             = epc_q;
  assign halted_p1          = (state_q == HALTED);

endmodule

// File: tb/tb_fetch_ifid.sv
// Directed bench for fetch_ifid: synchronous-read memory model whose words encode their address.
module tb_fetch_ifid;

  localparam logic [15:0] NOP = 16'h0800;

  logic        clk;
  logic        rst;
  logic        imem_en;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        stall, halt, illegal, rti, jmp;
  logic [15:0] disp;
  logic        redirect;
  logic [15:0] target;
  logic [15:0] pc;
  logic [15:0] inst;
  logic        valid;
  logic [15:0] epc;
  logic        halted;

  logic [15:0] mem [32768];
  int          tests;
  int          fails;

  fetch_ifid dut (
    .clk                            (clk),
    .rst                            (rst),
    .imem_en_p1                     (imem_en),
    .imem_addr_p1                   (imem_addr),
    .imem_rdata_p1                  (imem_rdata),
    .stall_idif_p1                  (stall),
    .halt_idif_p1                   (halt),
    .illegal_op_idif_p1             (illegal),
    .return_execution_idif_p1       (rti),
    .jmp_displacement_idif_p1       (jmp),
    .jmp_displacement_value_idif_p1 (disp),
    .redirect_ixif_p1               (redirect),
    .redirect_target_ixif_p1        (target),
    .pc_p1                          (pc),
    .inst_ifid_p1                   (inst),
    .inst_valid_ifid_p1             (valid),
    .epc_p1                         (epc),
    .halted_p1                      (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (imem_en === 1'b1) imem_rdata <= mem[imem_addr[15:1]];
  end

  function automatic logic [15:0] mv(input logic [15:0] a);
    return 16'h5A00 ^ a;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    stall = 0; halt = 0; illegal = 0; rti = 0; jmp = 0; disp = 0;
    redirect = 0; target = 0;
  endtask

  task automatic do_reset;
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tests = 0;
    fails = 0;
    imem_rdata = 16'h0000;
    for (int i = 0; i < 32768; i++) mem[i] = mv(16'(i * 2));
    clear_inputs();
    rst = 1'b1;

    // Reset state and straight-line fetch
    do_reset();
    chk("rst_valid", valid, 0);
    chk("rst_inst", inst, NOP);
    chk("rst_pc", pc, 0);
    chk("rst_epc", epc, 0);
    chk("rst_halted", halted, 0);
    chk("rst_en", imem_en, 1);
    chk("seq_addr0", imem_addr, 16'h0000);
    tick();
    chk("seq_addr1", imem_addr, 16'h0002);
    chk("seq_valid1", valid, 1);
    chk("seq_pc1", pc, 16'h0000);
    chk("seq_inst1", inst, mv(16'h0000));
    tick();
    chk("seq_addr2", imem_addr, 16'h0004);
    chk("seq_pc2", pc, 16'h0002);
    chk("seq_inst2", inst, mv(16'h0002));
    tick();
    chk("seq_addr3", imem_addr, 16'h0006);
    chk("seq_pc3", pc, 16'h0004);

    // J forward from 0x0004 with displacement 0x0010
    jmp = 1; disp = 16'h0010; #1;
    chk("jmp_addr", imem_addr, 16'h0006);
    tick();
    jmp = 0; disp = 0; #1;
    chk("jmp_bubble_valid", valid, 0);
    chk("jmp_bubble_inst", inst, NOP);
    chk("jmp_fetch", imem_addr, 16'h0016);
    tick();
    chk("jmp_valid", valid, 1);
    chk("jmp_pc", pc, 16'h0016);
    chk("jmp_inst", inst, mv(16'h0016));

    // Stall three cycles on 0x0006; halt during stall must be ignored
    do_reset();
    repeat (4) tick();
    stall = 1; #1;
    chk("stall0_pc", pc, 16'h0006);
    chk("stall0_valid", valid, 1);
    chk("stall0_inst", inst, mv(16'h0006));
    chk("stall0_addr", imem_addr, 16'h0006);
    tick();
    halt = 1; #1;
    chk("stall1_pc", pc, 16'h0006);
    chk("stall1_inst", inst, mv(16'h0006));
    chk("stall1_addr", imem_addr, 16'h0006);
    tick();
    halt = 0; #1;
    chk("stall2_pc", pc, 16'h0006);
    chk("stall2_inst", inst, mv(16'h0006));
    chk("stall2_halted", halted, 0);
    tick();
    stall = 0; #1;
    chk("rel_pc", pc, 16'h0006);
    chk("rel_addr", imem_addr, 16'h0008);
    chk("rel_inst", inst, mv(16'h0006));
    tick();
    chk("resume_pc", pc, 16'h0008);
    chk("resume_valid", valid, 1);
    chk("resume_inst", inst, mv(16'h0008));

    // Illegal op at 0x0020, concurrent J must lose
    do_reset();
    redirect = 1; target = 16'h0020; #1;
    tick();
    redirect = 0; target = 0; #1;
    chk("rd_bubble", valid, 0);
    chk("rd_addr", imem_addr, 16'h0020);
    tick();
    chk("ill_pc", pc, 16'h0020);
    chk("ill_valid", valid, 1);
    illegal = 1; jmp = 1; disp = 16'h0100;
`ifdef FETCH_EXC_TRAP_EN
    tick();
    clear_inputs(); #1;
    chk("trap_epc", epc, 16'h0022);
    chk("trap_bubble", valid, 0);
    chk("trap_addr", imem_addr, 16'h0002);
    chk("trap_halted", halted, 0);
    tick();
    chk("vec_pc", pc, 16'h0002);
    chk("vec_valid", valid, 1);
    rti = 1;
    tick();
    rti = 0; #1;
    chk("rti_bubble", valid, 0);
    chk("rti_addr", imem_addr, 16'h0022);
    tick();
    chk("rti_pc", pc, 16'h0022);
    chk("rti_valid", valid, 1);
    chk("rti_inst", inst, mv(16'h0022));
`else
    tick();
    clear_inputs(); #1;
    chk("illhalt_halted", halted, 1);
    chk("illhalt_en", imem_en, 0);
    chk("illhalt_valid", valid, 0);
    chk("illhalt_epc", epc, 16'h0000);
    rti = 1;
    tick();
    rti = 0; #1;
    chk("illhalt_stay", halted, 1);
    do_reset();
    tick();
    chk("rti0_pc", pc, 16'h0000);
    rti = 1;
    tick();
    rti = 0; #1;
    chk("rti0_bubble", valid, 0);
    chk("rti0_addr", imem_addr, 16'h0000);
    tick();
    chk("rti0_valid", valid, 1);
    chk("rti0_pc2", pc, 16'h0000);
`endif

    // Redirect beats a same-cycle halt
    do_reset();
    tick();
    redirect = 1; target = 16'h0100; halt = 1; #1;
    tick();
    clear_inputs(); #1;
    chk("prio_halted", halted, 0);
    chk("prio_bubble", valid, 0);
    chk("prio_addr", imem_addr, 16'h0100);
    tick();
    chk("prio_pc", pc, 16'h0100);
    chk("prio_valid", valid, 1);
    chk("prio_halted2", halted, 0);

    // HALT at 0x000A, inputs ignored, reset recovers
    do_reset();
    repeat (6) tick();
    chk("halt_at_pc", pc, 16'h000A);
    halt = 1;
    tick();
    halt = 0; #1;
    chk("halt_flag", halted, 1);
    chk("halt_en", imem_en, 0);
    chk("halt_valid", valid, 0);
    chk("halt_inst", inst, NOP);
    redirect = 1; target = 16'h0040;
    repeat (3) tick();
    redirect = 0; #1;
    chk("halt_hold", halted, 1);
    chk("halt_hold_en", imem_en, 0);
    chk("halt_hold_valid", valid, 0);
    do_reset();
    chk("unhalt_flag", halted, 0);
    chk("unhalt_en", imem_en, 1);
    chk("unhalt_addr", imem_addr, 16'h0000);
    tick();
    chk("unhalt_pc", pc, 16'h0000);
    chk("unhalt_valid", valid, 1);

    // PC wrap from 0xFFFE to 0x0000
    do_reset();
    redirect = 1; target = 16'hFFFE; #1;
    tick();
    redirect = 0; target = 0; #1;
    chk("wrap_fetch", imem_addr, 16'hFFFE);
    tick();
    chk("wrap_pc", pc, 16'hFFFE);
    chk("wrap_inst", inst, mv(16'hFFFE));
    chk("wrap_next", imem_addr, 16'h0000);
    tick();
    chk("wrap_pc0", pc, 16'h0000);
    chk("wrap_valid", valid, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_ifid.md
Name: fetch_ifid

Overview:
- Instruction fetch stage. Produces the IF/ID stream (pc, instruction, EPC) that the decoder consumes.
- Owns the PC, the EPC and the halt state.
- Drives a synchronous-read instruction memory with 1-cycle read latency.
- Acts on control feedback from decode (halt, illegal op, RTI, J/JAL) and on redirects from execute (branches, JR/JALR).

Parameters:
- RESET_PC, 16'h0000, PC loaded on reset.
- EXC_VECTOR, 16'h0002, PC loaded on an illegal-op trap.
- NOP_INST, 16'h0800, instruction word (opcode 00001) presented during bubbles.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- imem_en_p1  out  1  instruction memory read enable
- imem_addr_p1  out  16  instruction memory byte address
- imem_rdata_p1  in  16  read data for the address presented the previous cycle
- stall_idif_p1  in  1  downstream cannot accept; hold IF/ID contents
- halt_idif_p1  in  1  decode: HALT in IF/ID
- illegal_op_idif_p1  in  1  decode: illegal op in IF/ID
- return_execution_idif_p1  in  1  decode: RTI in IF/ID
- jmp_displacement_idif_p1  in  1  decode: J/JAL in IF/ID
- jmp_displacement_value_idif_p1  in  16  sign-extended displacement
- redirect_ixif_p1  in  1  execute: taken branch or JR/JALR
- redirect_target_ixif_p1  in  16  execute target PC
- pc_p1  out  16  address of the instruction in IF/ID
- inst_ifid_p1  out  16  instruction in IF/ID (NOP_INST when invalid)
- inst_valid_ifid_p1  out  1  IF/ID holds a real instruction
- epc_p1  out  16  exception PC
- halted_p1  out  1  fetch is halted

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- State: pc_q (next fetch address), pend_pc, pend_valid, epc_q, and an FSM with states RUN and HALTED.
- Reset values:
  - pc_q=RESET_PC, pend_pc=0, pend_valid=0, epc_q=0, state=RUN.
  - Outputs in the first cycle after reset: inst_valid_ifid_p1=0, inst_ifid_p1=NOP_INST, pc_p1=0, epc_p1=0, halted_p1=0.
  - rst mid-operation discards all pending state, including HALTED.
- IF/ID outputs:
  - inst_ifid_p1 = pend_valid ? imem_rdata_p1 : NOP_INST
  - inst_valid_ifid_p1 = pend_valid
  - pc_p1 = pend_pc
  - epc_p1 = epc_q
- Memory:
  - imem_en_p1 = (state==RUN).
  - imem_addr_p1 = stall_idif_p1 ? pend_pc : pc_q. Re-reading pend_pc keeps rdata stable across a stall.
  - Neither output depends combinationally on imem_rdata_p1.
- Decode feedback is qualified: dec_x = x & pend_valid & ~stall_idif_p1. A stalled instruction acts when it is released.
- Per-cycle priority in RUN (highest first):
  1. redirect_ixif_p1: pc_q<=redirect_target_ixif_p1, pend_valid<=0. Overrides stall and all decode feedback.
  2. dec_halt: state<=HALTED, pend_valid<=0.
  3. dec_illegal:
     - epc_q<=pend_pc+2, pc_q<=EXC_VECTOR, pend_valid<=0.
     - Overrides a concurrent dec_jmp.
  4. dec_rti: pc_q<=epc_q, pend_valid<=0.
  5. dec_jmp: pc_q<=pend_pc+2+jmp_displacement_value_idif_p1, pend_valid<=0.
  6. stall_idif_p1: hold pc_q, pend_pc, pend_valid.
  7. Otherwise: pend_pc<=pc_q, pend_valid<=1, pc_q<=pc_q+2.
- Redirect penalty: every redirect inserts exactly one NOP bubble. The target instruction is valid in IF/ID two cycles after the redirect cycle.
- HALTED:
  - imem_en_p1=0, inst_valid_ifid_p1=0, halted_p1=1.
  - pc_q frozen. All inputs except rst are ignored. Exit only via rst.
- Arithmetic: all PC math is 16-bit modulo 2^16 (0xFFFE+2 -> 0x0000); carry-out is discarded.
- No alignment check: bit 0 of a target passes through unchanged.

Optional Feature:
- Macro: FETCH_EXC_TRAP_EN.
- Defined: illegal-op trap behaves as specified above (EPC capture, vector to EXC_VECTOR).
- Undefined:
  - dec_illegal is treated exactly as dec_halt (state<=HALTED) and epc_q is never written.
  - dec_rti still loads pc_q<=epc_q, which stays 0 after reset.

Test Plan:
- Straight-line fetch: reset, memory of NOPs.
  - imem_addr_p1 sequence 0,2,4,6.
  - pc_p1 valid sequence 0,2,4 from cycle 2.
  - inst_valid_ifid_p1 goes 1 at cycle 2.
- J forward: J with displacement 16'h0010 at 0x0004.
  - One NOP bubble, then pc_p1=0x0016 valid.
  - imem_addr_p1 never presents 0x0008 as a valid instruction.
- Stall: stall_idif_p1 held 3 cycles with the instruction at 0x0006 in IF/ID.
  - pc_p1=0x0006 and inst_ifid_p1 stable for all 3 cycles.
  - imem_addr_p1=0x0006 during the stall.
  - Resumes at 0x0008.
- Exception round trip (macro defined): illegal op at 0x0020 then RTI at EXC_VECTOR.
  - epc_p1=0x0022; next valid pc_p1=0x0002.
  - After RTI, next valid pc_p1=0x0022.
- Priority: redirect_ixif_p1=1 with target 0x0100 in the same cycle as halt_idif_p1=1.
  - halted_p1 stays 0.
  - Next valid pc_p1=0x0100 after one bubble.
- Halt and reset: HALT at 0x000A.
  - halted_p1=1, imem_en_p1=0 indefinitely.
  - Pulse rst: pc restarts at 0x0000, halted_p1=0.
  - Also: wrap case, pc_q=0xFFFE fetch, next fetch address 0x0000.
